// File: rtl/gpu_pkg.sv
// Shared GPU definitions: VRAM pixel format, write-block geometry and the
// accumulator state encoding used by pixel_block_writer.
package gpu_pkg;

  localparam int PIX_W      = 16;
  localparam int BLK_PIX    = 8;
  localparam int BLK_ADDR_W = 16;
  localparam int BLK_DATA_W = PIX_W * BLK_PIX;

  // PSX VRAM halfword: bit 15 mask, 14:10 blue, 9:5 green, 4:0 red
  typedef struct packed {
    logic       mask;
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } pixel_t;

  typedef enum logic [1:0] {
    ACC_EMPTY  = 2'd0,
    ACC_FILL   = 2'd1,
    ACC_CLOSED = 2'd2
  } acc_state_t;

  function automatic pixel_t pack_pixel(input logic       set_mask,
                                        input logic [4:0] r,
                                        input logic [4:0] g,
                                        input logic [4:0] b);
    pixel_t p;
    p.mask = set_mask;
    p.b    = b;
    p.g    = g;
    p.r    = r;
    return p;
  endfunction

endpackage

// File: rtl/pbw_out_reg.sv
// Valid/ready holding register for finished write blocks. Lets the
// accumulator start the next block while this one waits for the arbiter.
module pbw_out_reg
  import gpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BLK_ADDR_W-1:0] in_addr,
  input  logic [BLK_DATA_W-1:0] in_data,
  input  logic [BLK_PIX-1:0]    in_mask,
  input  logic                  ready,
  output logic                  valid,
  output logic [BLK_ADDR_W-1:0] addr,
  output logic [BLK_DATA_W-1:0] data,
  output logic [BLK_PIX-1:0]    mask,
  output logic                  free
);

  // The register can take a new block when empty or when the current one leaves this cycle
  assign free = !valid || ready;

  // Capture a committed block, drop it once the arbiter accepts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      mask  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= in_addr;
      data  <= in_data;
      mask  <= in_mask;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_block_writer.sv
// Packs dithered 5:5:5 pixels into PSX VRAM halfwords and coalesces
// horizontally adjacent pixels into 8-pixel aligned write blocks with a
// per-pixel write mask. Blocks close on tag change, full mask or flush.
// Build option PBW_OUTPUT_BUFFER_EN: adds pbw_out_reg after the accumulator
// so a new block can fill while the previous one waits for the arbiter.
module pixel_block_writer
  import gpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pixValid,
  output logic                  o_pixReady,
  input  logic [9:0]            i_pixX,
  input  logic [8:0]            i_pixY,
  input  logic [4:0]            i_r,
  input  logic [4:0]            i_g,
  input  logic [4:0]            i_b,
  input  logic                  i_setMask,
  input  logic                  i_flush,
  output logic                  o_blkValid,
  input  logic                  i_blkReady,
  output logic [BLK_ADDR_W-1:0] o_blkAddr,
  output logic [BLK_DATA_W-1:0] o_blkData,
  output logic [BLK_PIX-1:0]    o_blkPixMask,
  output logic                  o_idle
);

  acc_state_t            state, state_next;
  logic                  flush_pend, flush_pend_next;
  logic [BLK_ADDR_W-1:0] tag;
  logic [BLK_DATA_W-1:0] data;
  logic [BLK_PIX-1:0]    mask;

  logic [BLK_ADDR_W-1:0] pix_tag;
  logic [2:0]            slot;
  logic [PIX_W-1:0]      pix_word;
  logic [BLK_PIX-1:0]    slot_bit;
  logic [BLK_DATA_W-1:0] fresh_data;
  logic [BLK_PIX-1:0]    mask_written;
  logic                  tag_match;
  logic                  pix_ready;
  logic                  pix_fire;
  logic                  start_new;
  logic                  commit;
  logic                  out_free;

  assign pix_tag   = {i_pixY, i_pixX[9:3]};
  assign slot      = i_pixX[2:0];
  assign pix_word  = pack_pixel(i_setMask, i_r, i_g, i_b);
  assign slot_bit  = BLK_PIX'(1) << slot;
  assign tag_match = (pix_tag == tag);

  assign pix_fire     = i_pixValid && pix_ready;
  assign start_new    = pix_fire && (state != ACC_FILL);
  assign mask_written = start_new ? slot_bit : (mask | slot_bit);
  assign o_pixReady   = pix_ready;

  // A pixel that opens a block lands in an otherwise cleared data word
  always_comb begin
    fresh_data = '0;
    fresh_data[{slot, 4'b0000} +: PIX_W] = pix_word;
  end

  // State register for the accumulator FSM and the pending-flush flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACC_EMPTY;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_next;
      flush_pend <= flush_pend_next;
    end
  end

  // Next-state: open on first pixel, close on full/flush/tag change, empty on commit
  always_comb begin
    state_next      = state;
    flush_pend_next = flush_pend;
    case (state)
      ACC_EMPTY: begin
        if (pix_fire) begin
          state_next      = (i_flush || mask_written == '1) ? ACC_CLOSED : ACC_FILL;
          flush_pend_next = i_flush;
        end else begin
          flush_pend_next = i_flush;
        end
      end
      ACC_FILL: begin
        if (i_flush || flush_pend) begin
          state_next      = ACC_CLOSED;
          flush_pend_next = 1'b1;
        end else if (pix_fire && mask_written == '1) begin
          state_next = ACC_CLOSED;
        end else if (i_pixValid && !tag_match) begin
          state_next = ACC_CLOSED;
        end
      end
      ACC_CLOSED: begin
        flush_pend_next = flush_pend | i_flush;
        if (commit) begin
          flush_pend_next = i_flush;
          if (pix_fire) begin
            state_next = i_flush ? ACC_CLOSED : ACC_FILL;
          end else begin
            state_next = ACC_EMPTY;
          end
        end
      end
      default: begin
        state_next      = ACC_EMPTY;
        flush_pend_next = 1'b0;
      end
    endcase
  end

  // Outputs of the FSM: pixel acceptance and block commit
  always_comb begin
    pix_ready = 1'b0;
    commit    = 1'b0;
    case (state)
      ACC_EMPTY:  pix_ready = 1'b1;
      ACC_FILL:   pix_ready = tag_match;
      ACC_CLOSED: begin
        commit = out_free;
`ifdef PBW_OUTPUT_BUFFER_EN
        pix_ready = out_free;
`else
        pix_ready = 1'b0;
`endif
      end
      default: pix_ready = 1'b0;
    endcase
  end

  // Accumulator datapath: later writes to the same slot overwrite earlier ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag  <= '0;
      data <= '0;
      mask <= '0;
    end else if (pix_fire) begin
      if (start_new) begin
        tag  <= pix_tag;
        data <= fresh_data;
        mask <= slot_bit;
      end else begin
        data[{slot, 4'b0000} +: PIX_W] <= pix_word;
        mask <= mask | slot_bit;
      end
    end
  end

`ifdef PBW_OUTPUT_BUFFER_EN
  pbw_out_reg u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (commit),
    .in_addr (tag),
    .in_data (data),
    .in_mask (mask),
    .ready   (i_blkReady),
    .valid   (o_blkValid),
    .addr    (o_blkAddr),
    .data    (o_blkData),
    .mask    (o_blkPixMask),
    .free    (out_free)
  );
`else
  assign o_blkValid   = (state == ACC_CLOSED);
  assign o_blkAddr    = tag;
  assign o_blkData    = data;
  assign o_blkPixMask = mask;
  assign out_free     = !o_blkValid || i_blkReady;
`endif

  assign o_idle = (state == ACC_EMPTY) && !o_blkValid && !flush_pend;

endmodule

// File: tb/tb_pixel_block_writer.sv
// Testbench for pixel_block_writer: table of single-pixel flushed blocks,
// then hand-written sequences for rows, tag changes, overwrites, flushes,
// back-pressure and reset. Expected blocks go into a scoreboard queue.
module tb_pixel_block_writer;
  import gpu_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pixValid;
  logic         o_pixReady;
  logic [9:0]   i_pixX;
  logic [8:0]   i_pixY;
  logic [4:0]   i_r, i_g, i_b;
  logic         i_setMask;
  logic         i_flush;
  logic         o_blkValid;
  logic         i_blkReady;
  logic [15:0]  o_blkAddr;
  logic [127:0] o_blkData;
  logic [7:0]   o_blkPixMask;
  logic         o_idle;

  always #5 clk = ~clk;

  pixel_block_writer dut (
    .clk          (clk),
    .rst          (rst),
    .i_pixValid   (i_pixValid),
    .o_pixReady   (o_pixReady),
    .i_pixX       (i_pixX),
    .i_pixY       (i_pixY),
    .i_r          (i_r),
    .i_g          (i_g),
    .i_b          (i_b),
    .i_setMask    (i_setMask),
    .i_flush      (i_flush),
    .o_blkValid   (o_blkValid),
    .i_blkReady   (i_blkReady),
    .o_blkAddr    (o_blkAddr),
    .o_blkData    (o_blkData),
    .o_blkPixMask (o_blkPixMask),
    .o_idle       (o_idle)
  );

  typedef struct {
    logic [15:0]  addr;
    logic [7:0]   mask;
    logic [127:0] data;
  } blk_t;

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [4:0]  r;
    logic [4:0]  g;
    logic [4:0]  b;
    logic        m;
    logic [15:0] exp_addr;
    logic [7:0]  exp_mask;
    logic [15:0] exp_word;
  } vec_t;

  blk_t sb[$];
  blk_t mon_exp;
  int   checks = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  function automatic logic [127:0] slotMask(input logic [7:0] m);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = m[i] ? 16'hFFFF : 16'h0000;
    return r;
  endfunction

  function automatic logic [127:0] fillSlots(input logic [7:0] m, input logic [15:0] w);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*16 +: 16] = w;
    return r;
  endfunction

  task automatic pushBlock(input logic [15:0] a, input logic [7:0] m, input logic [127:0] d);
    blk_t e;
    e.addr = a;
    e.mask = m;
    e.data = d;
    sb.push_back(e);
  endtask

  // Scoreboard: every handshake pops one expected block
  always @(negedge clk) begin
    if (!rst && o_blkValid && i_blkReady) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_block: got addr=%0h mask=%0h, want none",
                 o_blkAddr, o_blkPixMask);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("blk_addr", o_blkAddr, mon_exp.addr);
        checkOutput("blk_mask", o_blkPixMask, mon_exp.mask);
        checkOutput("blk_data", o_blkData & slotMask(mon_exp.mask),
                    mon_exp.data & slotMask(mon_exp.mask));
      end
    end
  end

  // Drive one pixel (called at posedge+1) and wait until accepted
  task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y,
                               input logic [4:0] r, input logic [4:0] g,
                               input logic [4:0] b, input logic m,
                               input logic fl, output int stalls);
    bit done;
    done = 0;
    stalls = 0;
    i_pixValid = 1'b1;
    i_pixX = x;
    i_pixY = y;
    i_r = r;
    i_g = g;
    i_b = b;
    i_setMask = m;
    i_flush = fl;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (o_pixReady) done = 1;
      else stalls++;
      @(posedge clk);
      #1;
      i_flush = 1'b0;
    end
    i_pixValid = 1'b0;
    i_flush = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL pix_accept: got timeout, want accepted x=%0d y=%0d", x, y);
    end
  endtask

  task automatic doFlush();
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (o_idle) seen = 1;
      @(posedge clk);
      #1;
    end
    checkOutput(name, 128'(seen), 128'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t         vecs[6];
    int           stalls, total, idx, cnt;
    bit           acc, stable, held_valid;
    logic [151:0] held;
    logic [127:0] d;

    rst = 1'b1;
    i_pixValid = 0; i_pixX = 0; i_pixY = 0; i_r = 0; i_g = 0; i_b = 0;
    i_setMask = 0; i_flush = 0; i_blkReady = 1'b1;

    // Reset values
    #3;
    checkOutput("rst_blkValid", 128'(o_blkValid), 128'd0);
    checkOutput("rst_blkAddr", 128'(o_blkAddr), 128'd0);
    checkOutput("rst_blkData", o_blkData, 128'd0);
    checkOutput("rst_blkMask", 128'(o_blkPixMask), 128'd0);
    checkOutput("rst_pixReady", 128'(o_pixReady), 128'd1);
    checkOutput("rst_idle", 128'(o_idle), 128'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Packing / address table: one pixel each, flushed in the same cycle
    vecs[0] = '{10'd0,    9'd0,   5'd0,  5'd0,  5'd0,  1'b0, 16'h0000, 8'h01, 16'h0000};
    vecs[1] = '{10'd1023, 9'd511, 5'd31, 5'd31, 5'd31, 1'b1, 16'hFFFF, 8'h80, 16'hFFFF};
    vecs[2] = '{10'd13,   9'd2,   5'd5,  5'd10, 5'd20, 1'b0, 16'h0101, 8'h20, 16'h5145};
    vecs[3] = '{10'd514,  9'd100, 5'd31, 5'd0,  5'd0,  1'b0, 16'h3240, 8'h04, 16'h001F};
    vecs[4] = '{10'd7,    9'd1,   5'd0,  5'd31, 5'd0,  1'b1, 16'h0080, 8'h80, 16'h83E0};
    vecs[5] = '{10'd800,  9'd300, 5'd1,  5'd1,  5'd1,  1'b0, 16'h9664, 8'h01, 16'h0421};
    for (int v = 0; v < 6; v++) begin
      pushBlock(vecs[v].exp_addr, vecs[v].exp_mask,
                fillSlots(vecs[v].exp_mask, vecs[v].exp_word));
      applyStimulus(vecs[v].x, vecs[v].y, vecs[v].r, vecs[v].g, vecs[v].b,
                    vecs[v].m, 1'b1, stalls);
      checkOutput("tbl_stall", 128'(stalls), 128'd0);
      waitIdle("tbl_idle");
    end

    // Full row x=0..7 at y=5 in 8 cycles
    pushBlock(16'h0280, 8'hFF, fillSlots(8'hFF, 16'h0C41));
    total = 0;
    for (int x = 0; x < 8; x++) begin
      applyStimulus(10'(x), 9'd5, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, stalls);
      total += stalls;
    end
    checkOutput("row_stalls", 128'(total), 128'd0);
    waitIdle("row_idle");
    checkOutput("row_idle_after", 128'(o_idle), 128'd1);

    // Tag change: x=10,11 then x=16
    d = '0;
    d[2*16 +: 16] = 16'h0004;
    d[3*16 +: 16] = 16'h2000;
    pushBlock(16'h0001, 8'h0C, d);
    pushBlock(16'h0002, 8'h01, fillSlots(8'h01, 16'h0421));
    applyStimulus(10'd10, 9'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, stalls);
    applyStimulus(10'd11, 9'd0, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, stalls);
    applyStimulus(10'd16, 9'd0, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0, stalls);
`ifdef PBW_OUTPUT_BUFFER_EN
    checkOutput("tagchg_stall", 128'(stalls), 128'd1);
`else
    checkOutput("tagchg_stall", 128'(stalls), 128'd2);
`endif
    doFlush();
    waitIdle("tagchg_idle");

    // Same slot written twice: later pixel wins
    pushBlock(16'h0000, 8'h08, fillSlots(8'h08, 16'h801F));
    applyStimulus(10'd3, 9'd0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, stalls);
    applyStimulus(10'd3, 9'd0, 5'd31, 5'd0, 5'd0, 1'b1, 1'b0, stalls);
    doFlush();
    waitIdle("overwrite_idle");

    // Pixel and flush in the same cycle, then flush on empty
    pushBlock(16'h0000, 8'h20, fillSlots(8'h20, 16'h1062));
    applyStimulus(10'd5, 9'd0, 5'd2, 5'd3, 5'd4, 1'b0, 1'b1, stalls);
    waitIdle("flushpix_idle");
    checkOutput("flushpix_idle_after", 128'(o_idle), 128'd1);
    doFlush();
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_blkValid) cnt++;
      @(posedge clk); #1;
    end
    checkOutput("empty_flush_blocks", 128'(cnt), 128'd0);
    checkOutput("empty_flush_idle", 128'(o_idle), 128'd1);

    // Back-pressure: stream 24 pixels at y=7 with ready low for 20 cycles
    for (int blk = 0; blk < 3; blk++) begin
      d = '0;
      for (int i = 0; i < 8; i++) d[i*16 +: 16] = {1'b0, 5'd1, 5'd0, 5'(blk*8 + i)};
      pushBlock(16'h0380 + 16'(blk), 8'hFF, d);
    end
    i_blkReady = 1'b0;
    idx = 0;
    stable = 1;
    held_valid = 0;
    held = '0;
    for (int c = 0; c < 20; c++) begin
      i_pixValid = 1'b1; i_pixX = idx[9:0]; i_pixY = 9'd7;
      i_r = idx[4:0]; i_g = 5'd0; i_b = 5'd1; i_setMask = 1'b0;
      @(negedge clk);
      acc = o_pixReady;
      if (held_valid && (!o_blkValid || {o_blkAddr, o_blkPixMask, o_blkData} !== held)) stable = 0;
      if (o_blkValid) begin
        held = {o_blkAddr, o_blkPixMask, o_blkData};
        held_valid = 1;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
`ifdef PBW_OUTPUT_BUFFER_EN
    checkOutput("bp_accepted", 128'(idx), 128'd16);
`else
    checkOutput("bp_accepted", 128'(idx), 128'd8);
`endif
    checkOutput("bp_pixready_low", 128'(o_pixReady), 128'd0);
    checkOutput("bp_blk_valid", 128'(o_blkValid), 128'd1);
    checkOutput("bp_outputs_stable", 128'(stable), 128'd1);
    i_blkReady = 1'b1;
    for (int c = 0; c < 100 && idx < 24; c++) begin
      i_pixValid = 1'b1; i_pixX = idx[9:0]; i_pixY = 9'd7;
      i_r = idx[4:0]; i_g = 5'd0; i_b = 5'd1; i_setMask = 1'b0;
      @(negedge clk);
      acc = o_pixReady;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    i_pixValid = 1'b0;
    checkOutput("bp_all_accepted", 128'(idx), 128'd24);
    waitIdle("bp_idle");

    // Reset while a block is partially filled
    applyStimulus(10'd0, 9'd9, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0, stalls);
    applyStimulus(10'd1, 9'd9, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0, stalls);
    applyStimulus(10'd2, 9'd9, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0, stalls);
    checkOutput("fill_not_idle", 128'(o_idle), 128'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_blkValid", 128'(o_blkValid), 128'd0);
    checkOutput("midrst_blkAddr", 128'(o_blkAddr), 128'd0);
    checkOutput("midrst_blkData", o_blkData, 128'd0);
    checkOutput("midrst_blkMask", 128'(o_blkPixMask), 128'd0);
    checkOutput("midrst_pixReady", 128'(o_pixReady), 128'd1);
    checkOutput("midrst_idle", 128'(o_idle), 128'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_blkValid) cnt++;
      @(posedge clk); #1;
    end
    checkOutput("postrst_blocks", 128'(cnt), 128'd0);
    checkOutput("postrst_idle", 128'(o_idle), 128'd1);

    checkOutput("sb_remaining", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
